// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter.
// Functional-unit indices, unit count and the CDB broadcast record.
package cdb_arbiter_pkg;

  localparam int NUM_FU       = 5;
  localparam int DATA_WIDTH   = 32;
  localparam int ROB_IX_WIDTH = 3;
  localparam int DEST_WIDTH   = 5;

  localparam int FU_ALU   = 0;
  localparam int FU_BRALU = 1;
  localparam int FU_MUL   = 2;
  localparam int FU_DIV   = 3;
  localparam int FU_MEM   = 4;

  typedef struct packed {
    logic                    valid;
    logic [DATA_WIDTH-1:0]   value;
    logic [ROB_IX_WIDTH-1:0] rob_ix;
    logic [DEST_WIDTH-1:0]   dest;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// Kept generic so issue-port arbitration can reuse it.
module rr_arbiter #(
  parameter int WIDTH = 5,
  parameter int IXW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IXW-1:0]   ptr,
  input  logic             enable,
  output logic [WIDTH-1:0] grant,
  output logic [IXW-1:0]   index,
  output logic             valid
);

  int j;

  // Scan ptr, ptr+1, ... modulo WIDTH and stop at the first request.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    j     = 0;
    if (enable) begin
      for (int k = 0; k < WIDTH; k++) begin
        j = (int'(ptr) + k) % WIDTH;
        if (!valid && req[j]) begin
          valid    = 1'b1;
          grant[j] = 1'b1;
          index    = IXW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among functional units, registered broadcast,
// and a saturating count of cycles in which units contended for the bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU       = cdb_arbiter_pkg::NUM_FU,
  parameter int DATA_WIDTH   = cdb_arbiter_pkg::DATA_WIDTH,
  parameter int ROB_IX_WIDTH = cdb_arbiter_pkg::ROB_IX_WIDTH,
  parameter int DEST_WIDTH   = cdb_arbiter_pkg::DEST_WIDTH,
  parameter int SRC_W        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 flush_in,
  input  logic [NUM_FU-1:0]                    fu_valid_in,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]    fu_data_in,
  input  logic [NUM_FU-1:0][ROB_IX_WIDTH-1:0]  fu_rob_ix_in,
  input  logic [NUM_FU-1:0][DEST_WIDTH-1:0]    fu_dest_in,
  output logic [NUM_FU-1:0]                    fu_read_out,
  output logic                                 cdb_valid_out,
  output logic [DATA_WIDTH-1:0]                cdb_value_out,
  output logic [ROB_IX_WIDTH-1:0]              cdb_rob_ix_out,
  output logic [DEST_WIDTH-1:0]                cdb_dest_out,
  output logic [SRC_W-1:0]                     cdb_src_out,
  output logic [15:0]                          conflict_count_out
);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] grant_ix;
  logic [SRC_W-1:0] next_ptr;
  logic             grant_valid;
  logic             contention;

  // Reset and flush both suppress the grant so no unit result is consumed.
  rr_arbiter #(.WIDTH(NUM_FU), .IXW(SRC_W)) u_rr (
    .req    (fu_valid_in),
    .ptr    (ptr),
    .enable (!flush_in && !rst_in),
    .grant  (fu_read_out),
    .index  (grant_ix),
    .valid  (grant_valid)
  );

  always_comb begin
    next_ptr   = ptr;
    contention = ($countones(fu_valid_in) >= 2) && !flush_in;
    if (grant_valid) begin
      next_ptr = (grant_ix == SRC_W'(NUM_FU - 1)) ? '0 : grant_ix + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr                <= '0;
      cdb_valid_out      <= 1'b0;
      cdb_value_out      <= '0;
      cdb_rob_ix_out     <= '0;
      cdb_dest_out       <= '0;
      cdb_src_out        <= '0;
      conflict_count_out <= '0;
    end else begin
      ptr           <= next_ptr;
      cdb_valid_out <= grant_valid;
      // Payload holds its last value while the broadcast is invalid.
      if (grant_valid) begin
        cdb_value_out  <= fu_data_in[grant_ix];
        cdb_rob_ix_out <= fu_rob_ix_in[grant_ix];
        cdb_dest_out   <= fu_dest_in[grant_ix];
        cdb_src_out    <= grant_ix;
      end
      if (contention && conflict_count_out != 16'hFFFF) begin
        conflict_count_out <= conflict_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_cdb_arbiter;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  flush_in;
  logic [4:0]            fu_valid_in;
  logic [4:0][31:0]      fu_data_in;
  logic [4:0][2:0]       fu_rob_ix_in;
  logic [4:0][4:0]       fu_dest_in;
  logic [4:0]            fu_read_out;
  logic                  cdb_valid_out;
  logic [31:0]           cdb_value_out;
  logic [2:0]            cdb_rob_ix_out;
  logic [4:0]            cdb_dest_out;
  logic [2:0]            cdb_src_out;
  logic [15:0]           conflict_count_out;

  int compared   = 0;
  int mismatched = 0;

  int          m_ptr;
  logic [15:0] m_cnt;
  logic        m_valid;
  logic [31:0] m_value;
  logic [2:0]  m_rob;
  logic [4:0]  m_dest;
  logic [2:0]  m_src;
  logic [4:0]  exp_read;
  logic [4:0]  obs_read;

  always #5 clk_in = ~clk_in;

  cdb_arbiter dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .flush_in           (flush_in),
    .fu_valid_in        (fu_valid_in),
    .fu_data_in         (fu_data_in),
    .fu_rob_ix_in       (fu_rob_ix_in),
    .fu_dest_in         (fu_dest_in),
    .fu_read_out        (fu_read_out),
    .cdb_valid_out      (cdb_valid_out),
    .cdb_value_out      (cdb_value_out),
    .cdb_rob_ix_out     (cdb_rob_ix_out),
    .cdb_dest_out       (cdb_dest_out),
    .cdb_src_out        (cdb_src_out),
    .conflict_count_out (conflict_count_out)
  );

  // Winner is the first valid unit met when walking the ring from the priority holder.
  function automatic int model_grant(logic [4:0] v, logic f, logic r, int p);
    if (f || r) return -1;
    for (int k = 0; k < 5; k++) begin
      if (v[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  // Applies one cycle of inputs, samples the strobe mid-cycle, advances the model at the edge.
  task automatic drive_cycle(input logic [4:0] v, input logic f, input logic r, input bit rnd);
    int g;
    rst_in      = r;
    flush_in    = f;
    fu_valid_in = v;
    if (rnd) begin
      for (int i = 0; i < 5; i++) begin
        fu_data_in[i]   = $urandom;
        fu_rob_ix_in[i] = 3'($urandom);
        fu_dest_in[i]   = 5'($urandom);
      end
    end
    #2;
    obs_read = fu_read_out;
    g        = model_grant(v, f, r, m_ptr);
    exp_read = (g >= 0) ? 5'(1 << g) : 5'b0;
    @(posedge clk_in);
    if (r) begin
      m_ptr = 0; m_cnt = 0; m_valid = 0; m_value = 0; m_rob = 0; m_dest = 0; m_src = 0;
    end else begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_value = fu_data_in[g];
        m_rob   = fu_rob_ix_in[g];
        m_dest  = fu_dest_in[g];
        m_src   = 3'(g);
        m_ptr   = (g + 1) % 5;
      end else begin
        m_valid = 1'b0;
      end
      if (!f && $countones(v) >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive_cycle(5'b11111, 1'b0, 1'b1, 1'b1);
      compared++;
      if (obs_read !== 5'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_read: got %b want %b", obs_read, 5'b0);
      end
      compared++;
      if (cdb_valid_out !== 1'b0 || conflict_count_out !== 16'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_state: got valid=%b cnt=%0d want valid=0 cnt=0", cdb_valid_out, conflict_count_out);
      end
    end
    compared++;
    if ({cdb_value_out, cdb_rob_ix_out, cdb_dest_out, cdb_src_out} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_fields: got %h/%0d/%0d/%0d want all zero", cdb_value_out, cdb_rob_ix_out, cdb_dest_out, cdb_src_out);
    end
    drive_cycle(5'b11111, 1'b0, 1'b0, 1'b1);
    compared++;
    if (obs_read !== 5'b00001) begin
      mismatched++;
      $display("[TB] FAIL reset_first_grant: got %b want %b", obs_read, 5'b00001);
    end
    compared++;
    if (cdb_valid_out !== 1'b1 || cdb_src_out !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_first_bcast: got valid=%b src=%0d want valid=1 src=0", cdb_valid_out, cdb_src_out);
    end
  endtask

  task automatic test_single();
    fu_data_in   = '0;
    fu_rob_ix_in = '0;
    fu_dest_in   = '0;
    fu_data_in[2]   = 32'h0000_002A;
    fu_rob_ix_in[2] = 3'd3;
    fu_dest_in[2]   = 5'd7;
    drive_cycle(5'b00100, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs_read !== 5'b00100) begin
      mismatched++;
      $display("[TB] FAIL single_read: got %b want %b", obs_read, 5'b00100);
    end
    compared++;
    if ({cdb_valid_out, cdb_value_out, cdb_rob_ix_out, cdb_dest_out, cdb_src_out} !== {1'b1, 32'd42, 3'd3, 5'd7, 3'd2}) begin
      mismatched++;
      $display("[TB] FAIL single_bcast: got v=%b val=%0d rob=%0d dest=%0d src=%0d want v=1 val=42 rob=3 dest=7 src=2",
               cdb_valid_out, cdb_value_out, cdb_rob_ix_out, cdb_dest_out, cdb_src_out);
    end
    drive_cycle(5'b00000, 1'b0, 1'b0, 1'b1);
    compared++;
    if (cdb_valid_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_idle: got valid=%b want 0", cdb_valid_out);
    end
  endtask

  task automatic test_fairness();
    drive_cycle(5'b00000, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(5'b11111, 1'b0, 1'b0, 1'b1);
      compared++;
      if (obs_read !== 5'(1 << (c % 5)) || cdb_src_out !== 3'(c % 5)) begin
        mismatched++;
        $display("[TB] FAIL fair_order[%0d]: got read=%b src=%0d want read=%b src=%0d",
                 c, obs_read, cdb_src_out, 5'(1 << (c % 5)), c % 5);
      end
    end
    compared++;
    if (conflict_count_out !== 16'd10) begin
      mismatched++;
      $display("[TB] FAIL fair_count: got %0d want 10", conflict_count_out);
    end
  endtask

  task automatic test_wrap_skip();
    drive_cycle(5'b00000, 1'b0, 1'b1, 1'b1);
    drive_cycle(5'b01000, 1'b0, 1'b0, 1'b1);
    drive_cycle(5'b10010, 1'b0, 1'b0, 1'b1);
    compared++;
    if (obs_read !== 5'b10000) begin
      mismatched++;
      $display("[TB] FAIL wrap_from_4: got %b want %b", obs_read, 5'b10000);
    end
    drive_cycle(5'b00010, 1'b0, 1'b0, 1'b1);
    compared++;
    if (obs_read !== 5'b00010) begin
      mismatched++;
      $display("[TB] FAIL wrap_skip_to_1: got %b want %b", obs_read, 5'b00010);
    end
    drive_cycle(5'b11111, 1'b0, 1'b0, 1'b1);
    compared++;
    if (obs_read !== 5'b00100) begin
      mismatched++;
      $display("[TB] FAIL wrap_ptr_2: got %b want %b", obs_read, 5'b00100);
    end
  endtask

  task automatic test_flush();
    drive_cycle(5'b00000, 1'b0, 1'b1, 1'b1);
    drive_cycle(5'b00010, 1'b0, 1'b0, 1'b1);
    drive_cycle(5'b01001, 1'b1, 1'b0, 1'b1);
    compared++;
    if (obs_read !== 5'b0 || cdb_valid_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_block: got read=%b valid=%b want read=0 valid=0", obs_read, cdb_valid_out);
    end
    compared++;
    if (conflict_count_out !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL flush_count: got %0d want 0", conflict_count_out);
    end
    drive_cycle(5'b01001, 1'b0, 1'b0, 1'b1);
    compared++;
    if (obs_read !== 5'b01000 || cdb_src_out !== 3'd3) begin
      mismatched++;
      $display("[TB] FAIL flush_resume: got read=%b src=%0d want read=01000 src=3", obs_read, cdb_src_out);
    end
  endtask

  task automatic test_random();
    logic [4:0] v;
    logic       f, r;
    drive_cycle(5'b00000, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 300; c++) begin
      v = 5'($urandom);
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 49) == 0);
      drive_cycle(v, f, r, 1'b1);
      compared++;
      if (obs_read !== exp_read) begin
        mismatched++;
        $display("[TB] FAIL rand_read[%0d]: got %b want %b", c, obs_read, exp_read);
      end
      compared++;
      if ({cdb_valid_out, cdb_value_out, cdb_rob_ix_out, cdb_dest_out, cdb_src_out, conflict_count_out}
          !== {m_valid, m_value, m_rob, m_dest, m_src, m_cnt}) begin
        mismatched++;
        $display("[TB] FAIL rand_cdb[%0d]: got v=%b val=%h rob=%0d dest=%0d src=%0d cnt=%0d want v=%b val=%h rob=%0d dest=%0d src=%0d cnt=%0d",
                 c, cdb_valid_out, cdb_value_out, cdb_rob_ix_out, cdb_dest_out, cdb_src_out, conflict_count_out,
                 m_valid, m_value, m_rob, m_dest, m_src, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    drive_cycle(5'b00000, 1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 65540; c++) begin
      drive_cycle(5'b11111, 1'b0, 1'b0, 1'b0);
      if (c == 65534) begin
        compared++;
        if (conflict_count_out !== 16'hFFFE) begin
          mismatched++;
          $display("[TB] FAIL sat_near: got %h want FFFE", conflict_count_out);
        end
      end
    end
    compared++;
    if (conflict_count_out !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL sat_final: got %h want FFFF", conflict_count_out);
    end
  endtask

  initial begin
    rst_in       = 1'b1;
    flush_in     = 1'b0;
    fu_valid_in  = '0;
    fu_data_in   = '0;
    fu_rob_ix_in = '0;
    fu_dest_in   = '0;
    m_ptr = 0; m_cnt = 0; m_valid = 0; m_value = 0; m_rob = 0; m_dest = 0; m_src = 0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_flush();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
